// File: rtl/gray_conv_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gray_conv_arbiter
//
// Several requesters share one serial Gray/binary code converter. A
// round-robin arbiter picks one pending request while the block is idle and
// captures that requester's operand and direction bit. The converter then
// resolves one result bit per cycle, MSB first. The result is held until the
// consumer accepts it.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : synchronous active-high reset
//   req        : per-requester request, held high until granted
//   mode       : per-requester direction, 0 = Gray->binary, 1 = binary->Gray
//   din        : per-requester operand, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, high only in the cycle the operand is captured
//   busy       : high whenever a conversion is in flight or awaiting pickup
//   dout       : converted result
//   dout_id    : index of the requester that owns dout
//   dout_valid : dout and dout_id hold a finished result
//   dout_ready : consumer accepts the result (ignored unless a result is held)
// ---------------------------------------------------------------------------
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         mode,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(N_REQ)-1:0] dout_id,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int ID_W = $clog2(N_REQ);
  // Bit index width covers 0..WIDTH so that "index + 1" can address the
  // zero guard bit sitting above the MSB of the operand and result.
  localparam int IX_W = $clog2(WIDTH + 1);
  localparam logic [ID_W:0] N_W = (ID_W + 1)'(N_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic [ID_W-1:0]  id_q;
  logic             cmode;
  logic [IX_W-1:0]  idx;
  logic [IX_W-1:0]  idx_up;
  // Operand and result carry an extra always-zero bit at position WIDTH,
  // which provides the r[WIDTH] = b[WIDTH] = 0 boundary for the MSB step.
  logic [WIDTH:0]   src;
  logic [WIDTH:0]   res;
  logic             hi_bit;
  logic             new_bit;
  logic [WIDTH-1:0] slice [N_REQ];

  // Modulo-N_REQ addition used for both the search order and pointer update.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    return sum[ID_W-1:0];
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice[g] = din[g*WIDTH +: WIDTH];
  end

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_add(ptr, (ID_W + 1)'(k));
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Grant only from IDLE and never while reset is asserted.
  always_comb begin
    gnt = '0;
    if (!rst && state == IDLE && found) begin
      gnt[sel] = 1'b1;
    end
  end

  // One conversion step. Both directions XOR the current operand bit with
  // the bit above it; Gray->binary takes that upper bit from the result
  // already resolved, binary->Gray takes it from the operand itself.
  always_comb begin
    idx_up  = idx + IX_W'(1);
    hi_bit  = cmode ? src[idx_up] : res[idx_up];
    new_bit = src[idx] ^ hi_bit;
  end

  // Main FSM: capture on grant, count idx down through CONV, hold in DONE
  // until accepted, then advance the pointer past the served requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      id_q  <= '0;
      cmode <= 1'b0;
      idx   <= '0;
      src   <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            src   <= {1'b0, slice[sel]};
            cmode <= mode[sel];
            id_q  <= sel;
            idx   <= IX_W'(WIDTH - 1);
            res   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          res[idx] <= new_bit;
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx <= idx - IX_W'(1);
          end
        end
        DONE: begin
          if (dout_ready) begin
            state <= IDLE;
            ptr   <= wrap_add(id_q, (ID_W + 1)'(1));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign dout_valid = (state == DONE);
  assign dout       = res[WIDTH-1:0];
  assign dout_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed bench for gray_conv_arbiter with N_REQ = 4, WIDTH = 4. Each grant
// pushes the expected {id, result} onto a scoreboard queue; each result the
// DUT presents pops and compares against it. Expected results come from
// whole-word reference conversions.
// ---------------------------------------------------------------------------
module tb_gray_conv_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  mode;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  dout;
  logic [1:0]  dout_id;
  logic        dout_valid;
  logic        dout_ready;

  int   checks;
  int   failures;
  exp_t sb[$];
  int   gid [5];
  int   gcyc [5];

  gray_conv_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .din       (din),
    .gnt       (gnt),
    .busy      (busy),
    .dout      (dout),
    .dout_id   (dout_id),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] refB2G(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] refG2B(input logic [3:0] g);
    logic [3:0] r;
    r[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      r[i] = g[i] ^ r[i+1];
    end
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a single request with its operand, check the same-cycle grant,
  // record the expected result, then drop the request after the grant edge.
  task automatic applyStimulus(input int id, input logic m, input logic [3:0] v,
                               input string tag);
    exp_t e;
    din[id*4 +: 4] = v;
    mode[id]       = m;
    req            = 4'b0000;
    req[id]        = 1'b1;
    #1;
    checkVal({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << id));
    e.id  = 2'(id);
    e.val = m ? refB2G(v) : refG2B(v);
    sb.push_back(e);
    @(negedge clk);
    req = 4'b0000;
  endtask

  // Wait (bounded) for dout_valid; optionally check how many cycles it took.
  task automatic waitValid(input string tag, input int expCycles);
    int n;
    n = 0;
    while (dout_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (expCycles >= 0) begin
      checkVal({tag, "_lat"}, 32'(n), 32'(expCycles));
    end else begin
      checkVal({tag, "_timeout"}, 32'(n < 40), 32'd1);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkVal({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkVal({tag, "_dout"}, 32'(dout), 32'(e.val));
      checkVal({tag, "_id"}, 32'(dout_id), 32'(e.id));
    end
  endtask

  task automatic accept(input string tag);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    checkVal({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkVal({tag, "_valid_after"}, 32'(dout_valid), 32'd0);
  endtask

  task automatic runOp(input int id, input logic m, input logic [3:0] v,
                       input string tag, input int roundTrip);
    applyStimulus(id, m, v, tag);
    waitValid(tag, WIDTH);
    if (roundTrip >= 0) begin
      checkVal({tag, "_round"}, 32'(dout), 32'(roundTrip));
    end
    checkOutput(tag);
    accept(tag);
  endtask

  initial begin
    logic [3:0] expV;
    int         gcount;
    int         cyc;
    int         oid;
    exp_t       e;

    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    req        = 4'b1111;
    mode       = 4'b0000;
    din        = 16'h0000;
    dout_ready = 1'b1;

    // Reset dominates requests and dout_ready.
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_gnt", 32'(gnt), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_valid", 32'(dout_valid), 32'd0);
    checkVal("rst_dout", 32'(dout), 32'd0);
    checkVal("rst_id", 32'(dout_id), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    req        = 4'b0000;
    dout_ready = 1'b0;

    // Gray->binary on requester 0, then binary->Gray on requester 2.
    runOp(0, 1'b0, 4'b1011, "t1", 13);
    runOp(2, 1'b1, 4'b1101, "t2", 11);

    // Stall in DONE; operand changes and a dropped request must not matter.
    applyStimulus(3, 1'b0, 4'b0110, "t3");
    expV            = refG2B(4'b0110);
    din[15:12]      = 4'b1111;
    mode[3]         = 1'b1;
    req             = 4'b0001;
    waitValid("t3", WIDTH);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkVal("t3_stall_valid", 32'(dout_valid), 32'd1);
      checkVal("t3_stall_dout", 32'(dout), 32'(expV));
      checkVal("t3_stall_id", 32'(dout_id), 32'd3);
      checkVal("t3_stall_gnt", 32'(gnt), 32'd0);
      if (i == 3) req = 4'b0011;
      if (i == 6) req = 4'b0010;
      @(negedge clk);
    end
    checkOutput("t3");
    mode[1]    = 1'b1;
    din[7:4]   = 4'b0011;
    dout_ready = 1'b1;
    #1;
    checkVal("t3_gnt_in_done", 32'(gnt), 32'd0);
    @(negedge clk);
    dout_ready = 1'b0;
    #1;
    checkVal("t4_gnt", 32'(gnt), 32'(4'b0010));
    checkVal("t4_busy_idle", 32'(busy), 32'd0);
    e.id  = 2'd1;
    e.val = refB2G(4'b0011);
    sb.push_back(e);
    @(negedge clk);
    req = 4'b0000;
    waitValid("t4", WIDTH);
    checkOutput("t4");
    accept("t4");

    // Reset in the second CONV cycle aborts the conversion.
    applyStimulus(2, 1'b1, 4'b1001, "t5");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("t5_busy", 32'(busy), 32'd0);
    checkVal("t5_dout", 32'(dout), 32'd0);
    checkVal("t5_valid", 32'(dout_valid), 32'd0);
    void'(sb.pop_back());
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("t5_no_result", 32'(dout_valid), 32'd0);
    end

    // All requesters pending, consumer always ready: fair rotation from 0.
    din        = {4'h3, 4'hC, 4'h5, 4'hA};
    mode       = 4'b1010;
    dout_ready = 1'b1;
    req        = 4'b1111;
    gcount     = 0;
    cyc        = 0;
    while (gcount < 5 && cyc < 80) begin
      #1;
      if (dout_valid === 1'b1) checkOutput("t6");
      if (gnt != 4'b0000) begin
        oid = 0;
        for (int k = 0; k < 4; k++) if (gnt[k]) oid = k;
        gid[gcount]  = oid;
        gcyc[gcount] = cyc;
        e.id  = 2'(oid);
        e.val = mode[oid] ? refB2G(din[oid*4 +: 4]) : refG2B(din[oid*4 +: 4]);
        sb.push_back(e);
        gcount++;
      end
      @(negedge clk);
      cyc++;
    end
    req = 4'b0000;
    checkVal("t6_count", 32'(gcount), 32'd5);
    waitValid("t6_last", -1);
    checkOutput("t6_last");
    @(negedge clk);
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < gcount) begin
        checkVal("t6_order", 32'(gid[k]), 32'(k % 4));
        if (k > 0) checkVal("t6_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(WIDTH + 2));
      end
    end

    // Every value, both directions, every requester, with round trip.
    for (int id = 0; id < 4; id++) begin
      for (int v = 0; v < 16; v++) begin
        runOp(id, 1'b1, 4'(v), "sw_b2g", -1);
        runOp(id, 1'b0, refB2G(4'(v)), "sw_g2b", v);
      end
    end

    checkVal("end_queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
